// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer for the CSR file.
// Accepts exceptions, interrupts and MRET, then strobes the CSR updates.
module trap_sequencer #(
   parameter int unsigned RESET_HOLD_CYCLES = 1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       stall_in,
   input  logic       illegal_instr_in,
   input  logic       misaligned_instr_in,
   input  logic       misaligned_load_in,
   input  logic       misaligned_store_in,
   input  logic       ecall_in,
   input  logic       ebreak_in,
   input  logic       mret_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       meip_in,
   input  logic       mtip_in,
   input  logic       msip_in,
   output logic       i_or_e_out,
   output logic [3:0] cause_out,
   output logic       set_cause_out,
   output logic       set_epc_out,
   output logic       mie_clear_out,
   output logic       mie_set_out,
   output logic       misaligned_exception_out,
   output logic       instret_inc_out,
   output logic [1:0] pc_src_out,
   output logic       flush_out
);

   typedef enum logic [1:0] {
      S_RESET,
      S_OPER,
      S_TAKEN,
      S_RETURN
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cause_q, cause_d;
   logic       ie_q, ie_d;
   logic       mis_q, mis_d;

   logic       exc;
   logic       mis_any;
   logic       ext_irq;
   logic       sw_irq;
   logic       tmr_irq;
   logic       irq;
   logic [3:0] exc_cause;
   logic [3:0] irq_cause;

   assign mis_any = misaligned_instr_in | misaligned_load_in
                  | misaligned_store_in;
   assign exc     = mis_any | illegal_instr_in | ecall_in | ebreak_in;
   assign ext_irq = meie_in & meip_in;
   assign sw_irq  = msie_in & msip_in;
   assign tmr_irq = mtie_in & mtip_in;
   assign irq     = mie_in & (ext_irq | sw_irq | tmr_irq);

   // Exception cause, highest-priority source first
   always_comb begin
      exc_cause = 4'd11;
      priority case (1'b1)
         misaligned_instr_in: exc_cause = 4'd0;
         illegal_instr_in:    exc_cause = 4'd2;
         ebreak_in:           exc_cause = 4'd3;
         misaligned_load_in:  exc_cause = 4'd4;
         misaligned_store_in: exc_cause = 4'd6;
         default:             exc_cause = 4'd11;
      endcase
   end

   // Interrupt cause: external, then software, then timer
   always_comb begin
      irq_cause = 4'd7;
      priority case (1'b1)
         ext_irq: irq_cause = 4'd11;
         sw_irq:  irq_cause = 4'd3;
         default: irq_cause = 4'd7;
      endcase
   end

   // Next-state, trap capture and Moore strobe decode
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      cause_d         = cause_q;
      ie_d            = ie_q;
      mis_d           = mis_q;
      set_cause_out   = 1'b0;
      set_epc_out     = 1'b0;
      mie_clear_out   = 1'b0;
      mie_set_out     = 1'b0;
      instret_inc_out = 1'b0;
      pc_src_out      = 2'b00;
      flush_out       = 1'b1;
      unique case (state_q)
         S_RESET: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = 4'd0;
               state_d = S_OPER;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_OPER: begin
            pc_src_out = 2'b10;
            flush_out  = 1'b0;
            if (!stall_in) begin
               if (exc) begin
                  cause_d = exc_cause;
                  ie_d    = 1'b0;
                  mis_d   = mis_any;
                  state_d = S_TAKEN;
               end else if (irq) begin
                  cause_d = irq_cause;
                  ie_d    = 1'b1;
                  mis_d   = 1'b0;
                  state_d = S_TAKEN;
               end else if (mret_in) begin
                  state_d = S_RETURN;
               end else begin
                  instret_inc_out = 1'b1;
               end
            end
         end
         S_TAKEN: begin
            set_cause_out = 1'b1;
            set_epc_out   = 1'b1;
            mie_clear_out = 1'b1;
            pc_src_out    = 2'b11;
            state_d       = S_OPER;
         end
         S_RETURN: begin
            mie_set_out = 1'b1;
            pc_src_out  = 2'b01;
            state_d     = S_OPER;
         end
         default: state_d = S_RESET;
      endcase
   end

   // State, hold counter and captured trap info
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_RESET;
         cnt_q   <= 4'd0;
         cause_q <= 4'd0;
         ie_q    <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         ie_q    <= ie_d;
         mis_q   <= mis_d;
      end
   end

   assign cause_out                = cause_q;
   assign i_or_e_out               = ie_q;
   assign misaligned_exception_out = mis_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer.
// Directed scenarios plus random traffic against a behavioural model.
module tb_trap_sequencer;

   localparam int HOLD = 3;

   logic       clk = 1'b0;
   logic       rst_in;
   logic       stall_in;
   logic       illegal_instr_in;
   logic       misaligned_instr_in;
   logic       misaligned_load_in;
   logic       misaligned_store_in;
   logic       ecall_in;
   logic       ebreak_in;
   logic       mret_in;
   logic       mie_in;
   logic       meie_in, mtie_in, msie_in;
   logic       meip_in, mtip_in, msip_in;
   logic       i_or_e_out;
   logic [3:0] cause_out;
   logic       set_cause_out;
   logic       set_epc_out;
   logic       mie_clear_out;
   logic       mie_set_out;
   logic       misaligned_exception_out;
   logic       instret_inc_out;
   logic [1:0] pc_src_out;
   logic       flush_out;

   int chk = 0;
   int err = 0;

   // model: cycles left in reset, pending one-cycle event, captured trap
   int         m_rst_left;
   int         m_phase;
   logic [3:0] m_cause;
   logic       m_ie;
   logic       m_mis;

   trap_sequencer #(.RESET_HOLD_CYCLES(HOLD)) dut (
      .clk_in                   (clk),
      .rst_in                   (rst_in),
      .stall_in                 (stall_in),
      .illegal_instr_in         (illegal_instr_in),
      .misaligned_instr_in      (misaligned_instr_in),
      .misaligned_load_in       (misaligned_load_in),
      .misaligned_store_in      (misaligned_store_in),
      .ecall_in                 (ecall_in),
      .ebreak_in                (ebreak_in),
      .mret_in                  (mret_in),
      .mie_in                   (mie_in),
      .meie_in                  (meie_in),
      .mtie_in                  (mtie_in),
      .msie_in                  (msie_in),
      .meip_in                  (meip_in),
      .mtip_in                  (mtip_in),
      .msip_in                  (msip_in),
      .i_or_e_out               (i_or_e_out),
      .cause_out                (cause_out),
      .set_cause_out            (set_cause_out),
      .set_epc_out              (set_epc_out),
      .mie_clear_out            (mie_clear_out),
      .mie_set_out              (mie_set_out),
      .misaligned_exception_out (misaligned_exception_out),
      .instret_inc_out          (instret_inc_out),
      .pc_src_out               (pc_src_out),
      .flush_out                (flush_out)
   );

   always #5 clk = ~clk;

   function automatic logic m_exc();
      return illegal_instr_in | misaligned_instr_in | misaligned_load_in
           | misaligned_store_in | ecall_in | ebreak_in;
   endfunction

   function automatic logic m_irq();
      return mie_in & ((meie_in & meip_in) | (msie_in & msip_in)
                     | (mtie_in & mtip_in));
   endfunction

   task automatic model_reset();
      m_rst_left = HOLD;
      m_phase    = 0;
      m_cause    = 4'd0;
      m_ie       = 1'b0;
      m_mis      = 1'b0;
   endtask

   // advance the model by one clock edge using the current inputs
   task automatic model_update();
      if (!rst_in) begin
         model_reset();
      end else if (m_rst_left > 0) begin
         m_rst_left--;
      end else if (m_phase != 0) begin
         m_phase = 0;
      end else if (!stall_in) begin
         if (m_exc()) begin
            if (misaligned_instr_in)      m_cause = 4'd0;
            else if (illegal_instr_in)    m_cause = 4'd2;
            else if (ebreak_in)           m_cause = 4'd3;
            else if (misaligned_load_in)  m_cause = 4'd4;
            else if (misaligned_store_in) m_cause = 4'd6;
            else                          m_cause = 4'd11;
            m_ie    = 1'b0;
            m_mis   = misaligned_instr_in | misaligned_load_in
                    | misaligned_store_in;
            m_phase = 1;
         end else if (m_irq()) begin
            if (meie_in & meip_in)      m_cause = 4'd11;
            else if (msie_in & msip_in) m_cause = 4'd3;
            else                        m_cause = 4'd7;
            m_ie    = 1'b1;
            m_mis   = 1'b0;
            m_phase = 1;
         end else if (mret_in) begin
            m_phase = 2;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clr();
      stall_in            = 1'b0;
      illegal_instr_in    = 1'b0;
      misaligned_instr_in = 1'b0;
      misaligned_load_in  = 1'b0;
      misaligned_store_in = 1'b0;
      ecall_in            = 1'b0;
      ebreak_in           = 1'b0;
      mret_in             = 1'b0;
      mie_in              = 1'b0;
      meie_in             = 1'b0;
      mtie_in             = 1'b0;
      msie_in             = 1'b0;
      meip_in             = 1'b0;
      mtip_in             = 1'b0;
      msip_in             = 1'b0;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      chk++;
      if ({pc_src_out, flush_out, set_cause_out, instret_inc_out,
           cause_out, i_or_e_out, misaligned_exception_out} !==
          {2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         err++;
         $display("FAIL reset_outs pc=%b fl=%b sc=%b ir=%b c=%0d",
                  pc_src_out, flush_out, set_cause_out,
                  instret_inc_out, cause_out);
      end
      tick();
      tick();
      rst_in = 1'b1;
      for (int i = 0; i < HOLD; i++) begin
         #2;
         chk++;
         if (pc_src_out !== 2'b00 || flush_out !== 1'b1) begin
            err++;
            $display("FAIL reset_hold%0d pc=%b fl=%b want 00/1",
                     i, pc_src_out, flush_out);
         end
         tick();
      end
      #2;
      chk++;
      if (pc_src_out !== 2'b10 || flush_out !== 1'b0 ||
          instret_inc_out !== 1'b1) begin
         err++;
         $display("FAIL reset_exit pc=%b fl=%b ir=%b want 10/0/1",
                  pc_src_out, flush_out, instret_inc_out);
      end
   endtask

   task automatic test_exception();
      illegal_instr_in = 1'b1;
      ecall_in         = 1'b1;
      #2;
      chk++;
      if (instret_inc_out !== 1'b0) begin
         err++;
         $display("FAIL exc_instret got=%b want 0", instret_inc_out);
      end
      tick();
      clr();
      #2;
      chk++;
      if ({cause_out, i_or_e_out, set_cause_out, set_epc_out,
           mie_clear_out, pc_src_out, flush_out,
           misaligned_exception_out} !==
          {4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0}) begin
         err++;
         $display("FAIL exc_taken c=%0d ie=%b sc=%b se=%b mc=%b pc=%b fl=%b",
                  cause_out, i_or_e_out, set_cause_out, set_epc_out,
                  mie_clear_out, pc_src_out, flush_out);
      end
      tick();
      #2;
      chk++;
      if (pc_src_out !== 2'b10 || set_cause_out !== 1'b0) begin
         err++;
         $display("FAIL exc_after pc=%b sc=%b want 10/0",
                  pc_src_out, set_cause_out);
      end
   endtask

   task automatic test_interrupt();
      mie_in  = 1'b1;
      meie_in = 1'b1;
      meip_in = 1'b1;
      mtie_in = 1'b1;
      mtip_in = 1'b1;
      tick();
      mie_in = 1'b0;
      #2;
      chk++;
      if (cause_out !== 4'd11 || i_or_e_out !== 1'b1 ||
          set_cause_out !== 1'b1) begin
         err++;
         $display("FAIL irq_taken c=%0d ie=%b sc=%b want 11/1/1",
                  cause_out, i_or_e_out, set_cause_out);
      end
      tick();
      #2;
      chk++;
      if (instret_inc_out !== 1'b1 || pc_src_out !== 2'b10) begin
         err++;
         $display("FAIL irq_masked ir=%b pc=%b want 1/10",
                  instret_inc_out, pc_src_out);
      end
      tick();
      #2;
      chk++;
      if (instret_inc_out !== 1'b1 || set_cause_out !== 1'b0) begin
         err++;
         $display("FAIL irq_masked2 ir=%b sc=%b want 1/0",
                  instret_inc_out, set_cause_out);
      end
      clr();
   endtask

   task automatic test_misaligned();
      misaligned_load_in = 1'b1;
      tick();
      misaligned_load_in = 1'b0;
      ebreak_in          = 1'b1;
      #2;
      chk++;
      if (cause_out !== 4'd4 || misaligned_exception_out !== 1'b1 ||
          i_or_e_out !== 1'b0) begin
         err++;
         $display("FAIL mis_load c=%0d mis=%b ie=%b want 4/1/0",
                  cause_out, misaligned_exception_out, i_or_e_out);
      end
      tick();
      tick();
      clr();
      #2;
      chk++;
      if (cause_out !== 4'd3 || misaligned_exception_out !== 1'b0 ||
          set_cause_out !== 1'b1) begin
         err++;
         $display("FAIL b2b_ebreak c=%0d mis=%b sc=%b want 3/0/1",
                  cause_out, misaligned_exception_out, set_cause_out);
      end
      tick();
   endtask

   task automatic test_mret();
      mret_in = 1'b1;
      #2;
      chk++;
      if (instret_inc_out !== 1'b0) begin
         err++;
         $display("FAIL mret_instret got=%b want 0", instret_inc_out);
      end
      tick();
      clr();
      #2;
      chk++;
      if ({mie_set_out, pc_src_out, flush_out, set_cause_out} !==
          {1'b1, 2'b01, 1'b1, 1'b0}) begin
         err++;
         $display("FAIL mret_ret ms=%b pc=%b fl=%b sc=%b want 1/01/1/0",
                  mie_set_out, pc_src_out, flush_out, set_cause_out);
      end
      tick();
      mret_in  = 1'b1;
      ecall_in = 1'b1;
      tick();
      clr();
      #2;
      chk++;
      if (cause_out !== 4'd11 || mie_set_out !== 1'b0 ||
          set_cause_out !== 1'b1 || i_or_e_out !== 1'b0) begin
         err++;
         $display("FAIL mret_ecall c=%0d ms=%b sc=%b ie=%b want 11/0/1/0",
                  cause_out, mie_set_out, set_cause_out, i_or_e_out);
      end
      tick();
   endtask

   task automatic test_stall_reset();
      stall_in = 1'b1;
      msie_in  = 1'b1;
      msip_in  = 1'b1;
      mie_in   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk++;
         if (set_cause_out !== 1'b0 || instret_inc_out !== 1'b0 ||
             pc_src_out !== 2'b10) begin
            err++;
            $display("FAIL stall%0d sc=%b ir=%b pc=%b want 0/0/10",
                     i, set_cause_out, instret_inc_out, pc_src_out);
         end
         tick();
      end
      stall_in = 1'b0;
      tick();
      #2;
      chk++;
      if (cause_out !== 4'd3 || i_or_e_out !== 1'b1 ||
          set_cause_out !== 1'b1) begin
         err++;
         $display("FAIL stall_release c=%0d ie=%b sc=%b want 3/1/1",
                  cause_out, i_or_e_out, set_cause_out);
      end
      do_reset();
      #1;
      chk++;
      if ({set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
           pc_src_out, flush_out, cause_out} !==
          {4'b0000, 2'b00, 1'b1, 4'd0}) begin
         err++;
         $display("FAIL reset_abort sc=%b se=%b mc=%b pc=%b c=%0d",
                  set_cause_out, set_epc_out, mie_clear_out,
                  pc_src_out, cause_out);
      end
      clr();
      tick();
      rst_in = 1'b1;
      for (int i = 0; i < HOLD; i++) tick();
   endtask

   task automatic test_random();
      logic [1:0] e_pc;
      logic       e_fl, e_sc, e_ms, e_ir;
      for (int n = 0; n < 800; n++) begin
         stall_in            = ($urandom_range(0, 3) == 0);
         illegal_instr_in    = ($urandom_range(0, 19) == 0);
         misaligned_instr_in = ($urandom_range(0, 19) == 0);
         misaligned_load_in  = ($urandom_range(0, 19) == 0);
         misaligned_store_in = ($urandom_range(0, 19) == 0);
         ecall_in            = ($urandom_range(0, 19) == 0);
         ebreak_in           = ($urandom_range(0, 19) == 0);
         mret_in             = ($urandom_range(0, 7) == 0);
         mie_in              = ($urandom_range(0, 3) == 0);
         {meie_in, mtie_in, msie_in} = 3'($urandom);
         {meip_in, mtip_in, msip_in} = 3'($urandom);
         if (rst_in && $urandom_range(0, 79) == 0) do_reset();
         else if (!rst_in && $urandom_range(0, 1) == 0) rst_in = 1'b1;
         #2;
         e_pc = 2'b00;
         e_fl = 1'b1;
         e_sc = 1'b0;
         e_ms = 1'b0;
         e_ir = 1'b0;
         if (m_rst_left == 0) begin
            if (m_phase == 1) begin
               e_pc = 2'b11;
               e_sc = 1'b1;
            end else if (m_phase == 2) begin
               e_pc = 2'b01;
               e_ms = 1'b1;
            end else begin
               e_pc = 2'b10;
               e_fl = 1'b0;
               e_ir = !stall_in && !m_exc() && !m_irq() && !mret_in;
            end
         end
         chk++;
         if ({pc_src_out, flush_out, set_cause_out, set_epc_out,
              mie_clear_out, mie_set_out, instret_inc_out, cause_out,
              i_or_e_out, misaligned_exception_out} !==
             {e_pc, e_fl, e_sc, e_sc, e_sc, e_ms, e_ir, m_cause,
              m_ie, m_mis}) begin
            err++;
            $display("FAIL random%0d got pc=%b fl=%b sc=%b se=%b mc=%b ms=%b ir=%b c=%0d ie=%b mis=%b want pc=%b fl=%b sc=%b ms=%b ir=%b c=%0d ie=%b mis=%b",
                     n, pc_src_out, flush_out, set_cause_out, set_epc_out,
                     mie_clear_out, mie_set_out, instret_inc_out,
                     cause_out, i_or_e_out, misaligned_exception_out,
                     e_pc, e_fl, e_sc, e_ms, e_ir, m_cause, m_ie, m_mis);
         end
         tick();
      end
   endtask

   initial begin
      clr();
      rst_in = 1'b0;
      model_reset();
      #3;
      test_reset();
      test_exception();
      test_interrupt();
      test_misaligned();
      test_mret();
      test_stall_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", chk, err);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Machine-mode control FSM that drives the trap/return side of the CSR file interface. It monitors exception strobes, `mret`, and the CSR file's enable/pending bits. It then issues the `set_cause`/`set_epc`/`mie_clear`/`mie_set` strobes, the cause code, the `i_or_e` flag and the `misaligned_exception` flag back to the CSR file. It also selects the PC source and flushes the pipeline on trap entry and return.

Parameters:
RESET_HOLD_CYCLES, 1, cycles spent in RESET after reset deassertion before fetch starts (legal range 1..15).

Ports:
clk_in  input  1  core clock.
rst_in  input  1  reset; asynchronous assert, active-low.
stall_in  input  1  pipeline stalled; no trap or return is accepted while high.
illegal_instr_in  input  1  illegal instruction detected.
misaligned_instr_in  input  1  instruction address misaligned.
misaligned_load_in  input  1  load address misaligned.
misaligned_store_in  input  1  store address misaligned.
ecall_in  input  1  ECALL decoded.
ebreak_in  input  1  EBREAK decoded.
mret_in  input  1  MRET decoded.
mie_in  input  1  mstatus.MIE from the CSR file.
meie_in, mtie_in, msie_in  input  1 each  interrupt enables.
meip_in, mtip_in, msip_in  input  1 each  interrupt pendings.
i_or_e_out  output  1  1 = interrupt, 0 = exception.
cause_out  output  4  trap cause code.
set_cause_out  output  1  load mcause/mtval strobe.
set_epc_out  output  1  load mepc strobe.
mie_clear_out  output  1  save MIE to MPIE and clear MIE.
mie_set_out  output  1  restore MIE from MPIE.
misaligned_exception_out  output  1  trap is a misaligned exception (qualifies the mtval capture).
instret_inc_out  output  1  instruction retired.
pc_src_out  output  2  PC source: 00 boot, 01 epc, 10 next, 11 trap address.
flush_out  output  1  kill the instruction in flight.

Behaviour:
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN. State is encoded in 2 bits; the hold counter is 4 bits.
- Reset (`rst_in` = 0), asynchronous:
  - State is RESET and the hold counter is 0.
  - `cause_out` = 0, `i_or_e_out` = 0, `misaligned_exception_out` = 0.
  - `pc_src_out` = 00 and `flush_out` = 1.
  - All strobes = 0 and `instret_inc_out` = 0.
- RESET:
  - Outputs `pc_src_out` = 00 and `flush_out` = 1.
  - The counter increments each cycle. When it reaches RESET_HOLD_CYCLES-1, the next state is OPERATING.
- OPERATING:
  - Outputs `pc_src_out` = 10 and `flush_out` = 0.
  - The following are evaluated only when `stall_in` = 0.
  - exc = OR of the six exception inputs.
  - irq = `mie_in` & ((meie&meip) | (msie&msip) | (mtie&mtip)).
  - Priority is exc > irq > mret.
  - Exception causes are priority-encoded in this order:
    - misaligned_instr: 0
    - illegal: 2
    - ebreak: 3
    - misaligned_load: 4
    - misaligned_store: 6
    - ecall: 11
  - Interrupt causes are priority-encoded in this order:
    - MEI: 11
    - MSI: 3
    - MTI: 7
  - On exc or irq:
    - Register `cause_out` and `i_or_e_out`.
    - `misaligned_exception_out` <= exc & (misaligned_instr | misaligned_load | misaligned_store).
    - Next state is TRAP_TAKEN.
  - On mret alone: next state is TRAP_RETURN.
  - Otherwise: `instret_inc_out` = 1 (combinational, OPERATING & !stall & !exc & !irq & !mret).
- TRAP_TAKEN (exactly 1 cycle):
  - `set_cause_out` = `set_epc_out` = `mie_clear_out` = 1.
  - `pc_src_out` = 11 and `flush_out` = 1.
  - Next state is OPERATING. Inputs are ignored.
- TRAP_RETURN (exactly 1 cycle):
  - `mie_set_out` = 1, `pc_src_out` = 01, `flush_out` = 1.
  - Next state is OPERATING.
- Registered outputs:
  - `cause_out`, `i_or_e_out` and `misaligned_exception_out` hold their values until the next trap is accepted.
  - All strobes are Moore outputs decoded from state.
- Boundary cases:
  - Stall: with `stall_in` = 1 in OPERATING, there is no transition and no `instret_inc_out`. A pending irq is taken on the first unstalled cycle.
  - Back-to-back: an irq still pending after a trap is masked, because the CSR file clears MIE in TRAP_TAKEN. An exception in the first OPERATING cycle after a trap is accepted normally.
  - Reset mid-operation: `rst_in` low in TRAP_TAKEN or TRAP_RETURN aborts immediately to RESET. No strobe is issued after reset asserts.

Test Plan:
1. Release reset with RESET_HOLD_CYCLES=3 -> `pc_src_out` = 00 and `flush_out` = 1 for 3 cycles, then 10. `instret_inc_out` = 1 on the next unstalled cycle.
2. Pulse `illegal_instr_in` and `ecall_in` together while unstalled -> next cycle `cause_out` = 2, `i_or_e_out` = 0, `set_cause_out` = `set_epc_out` = `mie_clear_out` = 1, `pc_src_out` = 11, `flush_out` = 1 for one cycle. Then OPERATING.
3. Set `mie_in` = 1, meie=meip=1, mtie=mtip=1 -> `cause_out` = 11, `i_or_e_out` = 1. Repeat with `mie_in` = 0 -> no trap, `instret_inc_out` stays 1.
4. Pulse `misaligned_load_in` -> `cause_out` = 4 and `misaligned_exception_out` = 1. A following ebreak -> `cause_out` = 3 and `misaligned_exception_out` = 0.
5. Pulse `mret_in` -> one cycle with `mie_set_out` = 1, `pc_src_out` = 01, `flush_out` = 1. `mret_in` together with `ecall_in` -> trap with cause 11 and no `mie_set_out`.
6. Hold `stall_in` = 1 with msie=msip=mie=1 for 4 cycles -> no strobes. Drop the stall -> TRAP_TAKEN with cause 3. Asserting `rst_in` = 0 during TRAP_TAKEN -> all strobes 0 in the same cycle and `pc_src_out` = 00.
